wb_result_arbiter: RTL
======================

// Module: wb_result_arbiter
// PURPOSE
// - Downstream neighbour of the execute stage. Collects results from NR_SRC execute result ports
//   (FLU, load, store, FPU, CV-X-IF) and drives NR_WB_PORTS scoreboard write-back ports.
// - Each source has its own small FIFO, so a unit that loses arbitration is stalled via src_ready_o
//   instead of losing its result.
// - The scoreboard always accepts write-back, so there is no ready signal on the output side.
// PARAMETERS
// - NR_SRC         default 5   number of execute result sources; index 0 is highest initial priority
// - NR_WB_PORTS    default 2   number of scoreboard write ports (1..NR_SRC)
// - FIFO_DEPTH     default 2   entries per source FIFO; power of 2, >= 2
// - XLEN           default 64  result and exception-cause width
// - TRANS_ID_BITS  default 3   scoreboard transaction-ID width
// PORTS
// - clk_i            in   1                        clock
// - rst_ni           in   1                        asynchronous reset, active low
// - flush_i          in   1                        pipeline flush; drop everything
// - src_valid_i      in   NR_SRC                   result valid per source
// - src_ready_o      out  NR_SRC                   source FIFO can accept this cycle
// - src_trans_id_i   in   NR_SRC x TRANS_ID_BITS   scoreboard ID per source
// - src_result_i     in   NR_SRC x XLEN            result data per source
// - src_ex_valid_i   in   NR_SRC                   result carries an exception
// - src_ex_cause_i   in   NR_SRC x XLEN            exception cause
// - wb_valid_o       out  NR_WB_PORTS              write-back valid
// - wb_trans_id_o    out  NR_WB_PORTS x TRANS_ID_BITS
// - wb_result_o      out  NR_WB_PORTS x XLEN
// - wb_ex_valid_o    out  NR_WB_PORTS
// - wb_ex_cause_o    out  NR_WB_PORTS x XLEN
// - conflict_cnt_o   out  32                       arbitration-conflict counter (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, rst_ni=0):
//   - all FIFOs empty; rr_ptr=0
//   - every wb_* output = 0; conflict_cnt_o = 0
//   - src_ready_o = all ones
// - Input side:
//   - src_ready_o[i] = !full[i], registered state only; no combinational path from wb or valid inputs.
//   - A push happens when src_valid_i[i] & src_ready_o[i] & !flush_i.
//   - A valid presented while ready=0 is the source's responsibility to hold; this block must not corrupt the FIFO.
// - Arbitration (every cycle, on registered FIFO state):
//   - Scan sources rr_ptr, rr_ptr+1, ... modulo NR_SRC.
//   - Grant the first min(NR_WB_PORTS, #non-empty) non-empty FIFOs.
//   - The k-th grant goes to write port k, and pops that FIFO head.
// - Output side:
//   - wb_* is registered: latency from push to wb_valid_o is 2 cycles minimum (FIFO write, then output register).
//   - Ungranted ports have wb_valid_o=0; their data outputs hold their previous value.
// - rr_ptr update: the cycle after any grant, rr_ptr = (last granted index + 1) mod NR_SRC. With no grant, rr_ptr is unchanged.
// - Same-FIFO push and pop in one cycle:
//   - allowed when not full: count is unchanged, and order is preserved (FIFO, never bypass).
//   - when full, ready was already 0, so only the pop occurs.
// - FIFO pointers wrap modulo FIFO_DEPTH; full/empty use a count of width $clog2(FIFO_DEPTH)+1.
// - flush_i=1 (synchronous):
//   - next cycle: all FIFOs empty, wb_valid_o=0, rr_ptr=0
//   - pushes in the flush cycle are dropped
//   - conflict_cnt_o is NOT cleared
// - Reset asserted mid-operation: immediate return to the reset values; no partial write-back is emitted.
// - A source is never granted twice in one cycle, even if its FIFO holds more than one entry.
// CONFIGURATION
// - Macro WB_ARB_CONFLICT_CNT_EN
//   - Defined: conflict_cnt_o increments by 1 in each cycle where at least one non-empty FIFO is
//     not granted. It saturates at 32'hFFFF_FFFF and resets only on rst_ni.
//   - Undefined: conflict_cnt_o is tied to 32'h0, and no counter flops are synthesised.
// TESTING
// - T1 single result: reset; push src1 id=3 res=0xAB for one cycle
//   -> 2 cycles later wb_valid_o[0]=1, wb_trans_id_o[0]=3, wb_result_o[0]=0xAB; wb_valid_o[1]=0.
// - T2 three-way conflict, default params: push src0 id=1, src2 id=2, src4 id=4 in the same cycle
//   -> next output: port0=id1, port1=id2; following cycle: port0=id4 only.
//   -> with the macro defined, conflict_cnt_o=1.
// - T3 backpressure: FIFO_DEPTH=2; hold src3 valid for 5 cycles while sources 0-2 and 4 are kept busy
//   -> src_ready_o[3]=0 once 2 entries are held; no entry lost or reordered; all IDs appear in push order.
// - T4 flush: fill src0 with 2 entries, assert flush_i for 1 cycle with src1 valid
//   -> next cycle wb_valid_o=0, src_ready_o all 1, src1 entry never written back.
// - T5 round-robin fairness: all 5 sources continuously valid for 20 cycles
//   -> every source granted exactly 8 times (40 grants), with no source idle for more than 3 cycles.
// - T6 exception pass-through: push src2 ex_valid=1, cause=0xD
//   -> wb_ex_valid_o=1, wb_ex_cause_o=0xD on the granted port.
// - T7 async reset: assert rst_ni=0 mid-burst
//   -> all outputs 0 immediately; after release, src_ready_o all 1.

Source files
------------

// File: rtl/wb_result_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_result_arbiter_if : execute-result and scoreboard write-back bundle     |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
interface wb_result_arbiter_if #(
  parameter int unsigned NR_SRC        = 5,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
);
  logic [NR_SRC-1:0]                          src_valid_i;
  logic [NR_SRC-1:0]                          src_ready_o;
  logic [NR_SRC-1:0][TRANS_ID_BITS-1:0]       src_trans_id_i;
  logic [NR_SRC-1:0][XLEN-1:0]                src_result_i;
  logic [NR_SRC-1:0]                          src_ex_valid_i;
  logic [NR_SRC-1:0][XLEN-1:0]                src_ex_cause_i;

  logic [NR_WB_PORTS-1:0]                     wb_valid_o;
  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]  wb_trans_id_o;
  logic [NR_WB_PORTS-1:0][XLEN-1:0]           wb_result_o;
  logic [NR_WB_PORTS-1:0]                     wb_ex_valid_o;
  logic [NR_WB_PORTS-1:0][XLEN-1:0]           wb_ex_cause_o;

  modport master (
    output src_valid_i, src_trans_id_i, src_result_i, src_ex_valid_i, src_ex_cause_i,
    input  src_ready_o,
    input  wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o, wb_ex_cause_o
  );

  modport slave (
    input  src_valid_i, src_trans_id_i, src_result_i, src_ex_valid_i, src_ex_cause_i,
    output src_ready_o,
    output wb_valid_o, wb_trans_id_o, wb_result_o, wb_ex_valid_o, wb_ex_cause_o
  );
endinterface
`default_nettype wire

// File: rtl/wb_result_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | wb_result_arbiter : per-source FIFOs, round-robin grant onto write-back    |
// | ports. Optional conflict counter enabled by WB_ARB_CONFLICT_CNT_EN.        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module wb_result_arbiter #(
  parameter int unsigned NR_SRC        = 5,
  parameter int unsigned NR_WB_PORTS   = 2,
  parameter int unsigned FIFO_DEPTH    = 2,
  parameter int unsigned XLEN          = 64,
  parameter int unsigned TRANS_ID_BITS = 3
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               flush_i,
  wb_result_arbiter_if.slave bus,
  output logic [31:0]        conflict_cnt_o
);
  localparam int unsigned SRC_W = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    logic                     ex_valid;
    logic [XLEN-1:0]          ex_cause;
  } entry_t;

  entry_t                 mem_q     [NR_SRC][FIFO_DEPTH];
  entry_t                 head      [NR_SRC];
  entry_t                 src_entry [NR_SRC];
  logic [PTR_W-1:0]       wr_ptr_q  [NR_SRC];
  logic [PTR_W-1:0]       wr_ptr_d  [NR_SRC];
  logic [PTR_W-1:0]       rd_ptr_q  [NR_SRC];
  logic [PTR_W-1:0]       rd_ptr_d  [NR_SRC];
  logic [CNT_W-1:0]       cnt_q     [NR_SRC];
  logic [CNT_W-1:0]       cnt_d     [NR_SRC];
  logic [NR_SRC-1:0]      full;
  logic [NR_SRC-1:0]      empty;
  logic [NR_SRC-1:0]      push;
  logic [NR_SRC-1:0]      grant;
  logic [SRC_W-1:0]       rr_ptr_q;
  logic [SRC_W-1:0]       rr_ptr_d;
  logic [NR_WB_PORTS-1:0] port_valid;
  logic [SRC_W-1:0]       port_src  [NR_WB_PORTS];
  logic [NR_WB_PORTS-1:0] wb_valid_q;
  logic [NR_WB_PORTS-1:0] wb_valid_d;
  entry_t                 wb_q      [NR_WB_PORTS];
  entry_t                 wb_d      [NR_WB_PORTS];

  for (genvar s = 0; s < NR_SRC; s++) begin : g_src
    assign full[s]      = (cnt_q[s] == CNT_W'(FIFO_DEPTH));
    assign empty[s]     = (cnt_q[s] == '0);
    assign push[s]      = bus.src_valid_i[s] & ~full[s] & ~flush_i;
    assign head[s]      = mem_q[s][rd_ptr_q[s]];
    assign src_entry[s] = '{trans_id: bus.src_trans_id_i[s],
                            result:   bus.src_result_i[s],
                            ex_valid: bus.src_ex_valid_i[s],
                            ex_cause: bus.src_ex_cause_i[s]};
  end

  // Ready depends only on registered occupancy, never on this cycle's grants.
  assign bus.src_ready_o = ~full;

  // Walk sources in rotated order; the k-th non-empty one takes write port k.
  always_comb begin
    int unsigned n;
    int unsigned pos;
    grant      = '0;
    port_valid = '0;
    rr_ptr_d   = rr_ptr_q;
    n          = 0;
    pos        = 0;
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) port_src[p] = '0;
    for (int unsigned k = 0; k < NR_SRC; k++) begin
      pos = 32'(rr_ptr_q) + k;
      if (pos >= NR_SRC) pos = pos - NR_SRC;
      for (int unsigned s = 0; s < NR_SRC; s++) begin
        if ((pos == s) && !empty[s] && (n < NR_WB_PORTS)) begin
          grant[s] = 1'b1;
          for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
            if (p == n) begin
              port_valid[p] = 1'b1;
              port_src[p]   = SRC_W'(s);
            end
          end
          rr_ptr_d = (s == NR_SRC - 1) ? '0 : SRC_W'(s + 1);
          n        = n + 1;
        end
      end
    end
    if (flush_i) rr_ptr_d = '0;
  end

  always_comb begin
    for (int unsigned s = 0; s < NR_SRC; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s];
      rd_ptr_d[s] = rd_ptr_q[s];
      cnt_d[s]    = cnt_q[s];
      if (flush_i) begin
        wr_ptr_d[s] = '0;
        rd_ptr_d[s] = '0;
        cnt_d[s]    = '0;
      end else begin
        if (push[s])  wr_ptr_d[s] = wr_ptr_q[s] + PTR_W'(1);
        if (grant[s]) rd_ptr_d[s] = rd_ptr_q[s] + PTR_W'(1);
        case ({push[s], grant[s]})
          2'b10:   cnt_d[s] = cnt_q[s] + CNT_W'(1);
          2'b01:   cnt_d[s] = cnt_q[s] - CNT_W'(1);
          default: cnt_d[s] = cnt_q[s];
        endcase
      end
    end
  end

  // Data registers of idle ports keep their last value.
  always_comb begin
    wb_valid_d = flush_i ? '0 : port_valid;
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      wb_d[p] = wb_q[p];
      if (port_valid[p] && !flush_i) wb_d[p] = head[port_src[p]];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned s = 0; s < NR_SRC; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        cnt_q[s]    <= '0;
      end
      rr_ptr_q   <= '0;
      wb_valid_q <= '0;
      for (int unsigned p = 0; p < NR_WB_PORTS; p++) wb_q[p] <= '0;
    end else begin
      for (int unsigned s = 0; s < NR_SRC; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        cnt_q[s]    <= cnt_d[s];
      end
      rr_ptr_q   <= rr_ptr_d;
      wb_valid_q <= wb_valid_d;
      for (int unsigned p = 0; p < NR_WB_PORTS; p++) wb_q[p] <= wb_d[p];
    end
  end

  always_ff @(posedge clk_i) begin
    for (int unsigned s = 0; s < NR_SRC; s++) begin
      if (push[s]) mem_q[s][wr_ptr_q[s]] <= src_entry[s];
    end
  end

  for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_wb
    assign bus.wb_valid_o[p]    = wb_valid_q[p];
    assign bus.wb_trans_id_o[p] = wb_q[p].trans_id;
    assign bus.wb_result_o[p]   = wb_q[p].result;
    assign bus.wb_ex_valid_o[p] = wb_q[p].ex_valid;
    assign bus.wb_ex_cause_o[p] = wb_q[p].ex_cause;
  end

`ifdef WB_ARB_CONFLICT_CNT_EN
  logic [31:0] conflict_cnt_q;
  logic [31:0] conflict_cnt_d;
  logic        conflict;

  assign conflict = |(~empty & ~grant);

  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (conflict && (conflict_cnt_q != 32'hFFFF_FFFF)) conflict_cnt_d = conflict_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) conflict_cnt_q <= '0;
    else         conflict_cnt_q <= conflict_cnt_d;
  end

  assign conflict_cnt_o = conflict_cnt_q;
`else
  assign conflict_cnt_o = 32'h0;
`endif

endmodule
`default_nettype wire
